mul_rs_multi: RTL and testbench
===============================

Name: mul_rs_multi

Overview:
- Parametrised successor to the single-lane multiply reservation station.
- Holds up to RS_ENTRIES M-extension multiply ops (MUL/MULH/MULHSU/MULHU) and captures operands from the regfile, the ROB and CDB snooping.
- Dispatches ready entries oldest-first to NUM_LANES independent iterative multipliers.
- Returns one result per cycle to the CDB under a valid/ready handshake, and supports a pipeline flush.

Parameters:
- RS_ENTRIES, 8: number of station entries; must be ≥2.
- NUM_LANES, 2: number of parallel shift_add_multiplier instances; 1..4.
- ROB_DEPTH, 3: ROB tag width in bits.
- CDB_SIZE, 2: number of CDB broadcast ports snooped.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (asserted when 0).
- flush  in  1  squash all entries and in-flight lanes.
- rs_full  out  1  no free entry (registered state).
- rs_count  out  $clog2(RS_ENTRIES)+1  occupied entries.
- rs_issue  in  1  allocate an entry this cycle.
- funct3  in  3  multiply variant.
- issue_rs1_regfile_ready, issue_rs2_regfile_ready  in  1  operand ready in regfile.
- issue_rs1_regfile_v, issue_rs2_regfile_v  in  32  regfile values.
- issue_rs1_regfile_rob, issue_rs2_regfile_rob  in  ROB_DEPTH  producer tags.
- issue_rs1_rob_ready, issue_rs2_rob_ready  in  1  operand ready in ROB.
- issue_rs1_rob_v, issue_rs2_rob_v  in  32  ROB values.
- issue_target_rob  in  ROB_DEPTH  destination tag.
- cdb_valid  in  1 x CDB_SIZE  broadcast valid.
- cdb_rob  in  ROB_DEPTH x CDB_SIZE  broadcast tag.
- cdb_rd_v  in  32 x CDB_SIZE  broadcast value.
- out_valid  out  1  result available.
- out_ready  in  1  CDB grant.
- out_p  out  32  result.
- out_rob  out  ROB_DEPTH  result tag.

Behaviour:
- Reset (rst=0 at clk edge):
  - All entries free, all lanes idle, age ranks cleared.
  - Outputs: rs_full=0, rs_count=0, out_valid=0, out_p=0, out_rob=0.
  - Reset mid-multiply aborts the multiply and discards the result.
- Issue:
  - When rs_issue=1 and rs_full=0, the lowest-index free entry is filled.
  - Operand priority per source: regfile ready, then ROB ready, then wait on the CDB tag.
  - The new entry's age rank = rs_count; rs_count increments.
  - rs_issue while rs_full=1 is ignored; upstream must not do this. rs_full does not see a same-cycle free.
- CDB snoop: each cycle, every occupied entry with a non-ready operand whose tag matches any cdb_valid port captures that value. If several ports match, the highest port index wins.
- Select: each cycle, at most one entry is dispatched to the lowest-index idle lane.
  - Candidate = the occupied, both-operands-ready, not-yet-dispatched entry with the smallest age rank.
  - Dispatch sets the entry's dispatched bit; the lane latches a, b, mul_type and funct3, then pulses start one cycle later.
  - mul_type mapping: MUL/MULH = signed x signed, MULHSU = signed x unsigned, MULHU = unsigned x unsigned.
  - Operands captured from the CDB become dispatchable the cycle after capture.
- Lane completion:
  - On done, the lane enters HOLD with p = low word for MUL, high word otherwise.
  - Lane FSM: IDLE -> START (1 cycle) -> BUSY -> HOLD -> IDLE.
  - HOLD exits only when that lane is the one driven to the output and out_ready=1.
- Output:
  - out_valid=1 when any lane is in HOLD; the lowest-index HOLD lane drives out_p and out_rob.
  - Handshake: the transfer occurs on a cycle with out_valid & out_ready. On transfer the lane returns to IDLE, its entry is freed, and every entry with a larger age rank decrements its rank.
  - out_p and out_rob must stay stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - Issue and free in the same cycle: rs_count is unchanged. The new entry's rank is computed after the decrement, i.e. rs_count-1.
  - A lane freed by a transfer can accept a dispatch in the next cycle.
- Flush: at the next edge, all entries are freed, lanes return to IDLE with results dropped, out_valid=0, rs_count=0. Flush has priority over issue.

Optional Feature:
- Macro: MUL_RS_ISSUE_BYPASS_EN.
- When defined: at issue, a not-ready operand whose tag matches a same-cycle cdb_valid port is captured as ready immediately, closing the one-cycle window in which that broadcast would otherwise be missed.
- When undefined: no issue-time bypass. Upstream guarantees that the regfile/ROB ready inputs already reflect the same-cycle CDB broadcast.

Test Plan:
- Reset, then issue MUL with rs1=7 and rs2=6 both regfile-ready, out_ready=1 -> out_valid with out_p=42 and the issued out_rob; rs_count returns to 0.
- MULH with rs1=0x80000000 and rs2=2 -> out_p=0xFFFFFFFF. MULHU with the same operands -> out_p=1. MULHSU with rs1=-1 and rs2=0xFFFFFFFF -> out_p=0xFFFFFFFF.
- Issue A (waits on tag 3), then B (ready); NUM_LANES=1 -> B completes first. cdb_valid[1] with tag 3 and value 5 -> A completes with its product.
- Two lanes finish together, out_ready=0 for 4 cycles -> lane 0's result is held stable. out_ready=1 -> lane 0 transfers, then lane 1 on the next cycle.
- Fill 8 entries -> rs_full=1 and rs_count=8; a ninth issue is ignored. flush -> next cycle rs_count=0, out_valid=0, no stale result ever appears.
- With the macro defined, issue rs1 on tag 2 while cdb_valid[0] carries tag 2 with value 9 in the same cycle -> the entry dispatches without a further broadcast. Without the macro, the entry waits.

Source files
------------

// File: rtl/mul_rs_multi.sv
// Multi-lane multiply reservation station with oldest-first dispatch to iterative multipliers.
// Define MUL_RS_ISSUE_BYPASS_EN to capture same-cycle CDB broadcasts at issue.

module shift_add_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_start,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [1:0]  i_mul_type,
    output logic        o_done,
    output logic [63:0] o_p
);
    logic        r_busy;
    logic [4:0]  r_cnt;
    logic        r_neg;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_ma;
    logic [31:0] w_mb;
    logic [63:0] w_sum;

    // Multiply magnitudes, then restore the sign of the full product.
    always_comb begin
        w_sa  = (i_mul_type != 2'd2) && i_a[31];
        w_sb  = (i_mul_type == 2'd0) && i_b[31];
        w_ma  = w_sa ? (~i_a + 32'd1) : i_a;
        w_mb  = w_sb ? (~i_b + 32'd1) : i_b;
        w_sum = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst || i_clear) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            o_done   <= 1'b0;
            o_p      <= '0;
        end else begin
            o_done <= 1'b0;
            if (i_start) begin
                r_busy   <= 1'b1;
                r_cnt    <= '0;
                r_neg    <= w_sa ^ w_sb;
                r_acc    <= '0;
                r_mcand  <= {32'd0, w_ma};
                r_mplier <= w_mb;
            end else if (r_busy) begin
                r_acc    <= w_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    r_busy <= 1'b0;
                    o_done <= 1'b1;
                    o_p    <= r_neg ? (~w_sum + 64'd1) : w_sum;
                end
            end
        end
    end
endmodule

module mul_rs_multi #(
    parameter int RS_ENTRIES = 8,
    parameter int NUM_LANES  = 2,
    parameter int ROB_DEPTH  = 3,
    parameter int CDB_SIZE   = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    output logic                                rs_full,
    output logic [$clog2(RS_ENTRIES):0]         rs_count,
    input  logic                                rs_issue,
    input  logic [2:0]                          funct3,
    input  logic                                issue_rs1_regfile_ready,
    input  logic                                issue_rs2_regfile_ready,
    input  logic [31:0]                         issue_rs1_regfile_v,
    input  logic [31:0]                         issue_rs2_regfile_v,
    input  logic [ROB_DEPTH-1:0]                issue_rs1_regfile_rob,
    input  logic [ROB_DEPTH-1:0]                issue_rs2_regfile_rob,
    input  logic                                issue_rs1_rob_ready,
    input  logic                                issue_rs2_rob_ready,
    input  logic [31:0]                         issue_rs1_rob_v,
    input  logic [31:0]                         issue_rs2_rob_v,
    input  logic [ROB_DEPTH-1:0]                issue_target_rob,
    input  logic [CDB_SIZE-1:0]                 cdb_valid,
    input  logic [CDB_SIZE-1:0][ROB_DEPTH-1:0]  cdb_rob,
    input  logic [CDB_SIZE-1:0][31:0]           cdb_rd_v,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [31:0]                         out_p,
    output logic [ROB_DEPTH-1:0]                out_rob
);
    localparam int CW = $clog2(RS_ENTRIES) + 1;
    localparam int IW = $clog2(RS_ENTRIES);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {L_IDLE, L_START, L_BUSY, L_HOLD} lane_st_t;

    logic [RS_ENTRIES-1:0] r_valid;
    logic [RS_ENTRIES-1:0] r_disp;
    logic [RS_ENTRIES-1:0] r_rdy1;
    logic [RS_ENTRIES-1:0] r_rdy2;
    logic [CW-1:0]         r_rank [RS_ENTRIES];
    logic [31:0]           r_v1   [RS_ENTRIES];
    logic [31:0]           r_v2   [RS_ENTRIES];
    logic [ROB_DEPTH-1:0]  r_t1   [RS_ENTRIES];
    logic [ROB_DEPTH-1:0]  r_t2   [RS_ENTRIES];
    logic [ROB_DEPTH-1:0]  r_rob  [RS_ENTRIES];
    logic [2:0]            r_f3   [RS_ENTRIES];
    logic [CW-1:0]         r_count;
    logic                  r_full;

    lane_st_t              r_ls   [NUM_LANES];
    logic [31:0]           r_la   [NUM_LANES];
    logic [31:0]           r_lb   [NUM_LANES];
    logic [2:0]            r_lf3  [NUM_LANES];
    logic [IW-1:0]         r_lent [NUM_LANES];
    logic [ROB_DEPTH-1:0]  r_lrob [NUM_LANES];
    logic [31:0]           r_lp   [NUM_LANES];
    logic                  r_lock_v;
    logic [LW-1:0]         r_lock_lane;

    logic [NUM_LANES-1:0]  w_done;
    logic [63:0]           w_prod [NUM_LANES];
    logic [1:0]            w_mt   [NUM_LANES];
    logic [IW-1:0]         w_free_idx;
    logic [IW-1:0]         w_sel_idx;
    logic                  w_sel_ok;
    logic [CW-1:0]         w_best;
    logic [LW-1:0]         w_lane_idx;
    logic                  w_lane_ok;
    logic [LW-1:0]         w_hold_idx;
    logic                  w_hold_ok;
    logic [LW-1:0]         w_out_lane;
    logic                  w_issue;
    logic                  w_disp;
    logic                  w_xfer;
    logic [IW-1:0]         w_xfer_ent;
    logic [CW-1:0]         w_xfer_rank;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_i1_base;
    logic                  w_i2_base;
    logic                  w_i1_rdy;
    logic                  w_i2_rdy;
    logic [31:0]           w_i1_v;
    logic [31:0]           w_i2_v;

    always_comb begin
        w_i1_base = issue_rs1_regfile_ready | issue_rs1_rob_ready;
        w_i2_base = issue_rs2_regfile_ready | issue_rs2_rob_ready;
        w_i1_rdy  = w_i1_base;
        w_i2_rdy  = w_i2_base;
        w_i1_v    = issue_rs1_regfile_ready ? issue_rs1_regfile_v : issue_rs1_rob_v;
        w_i2_v    = issue_rs2_regfile_ready ? issue_rs2_regfile_v : issue_rs2_rob_v;
`ifdef MUL_RS_ISSUE_BYPASS_EN
        for (int c = 0; c < CDB_SIZE; c++) begin
            if (!w_i1_base && cdb_valid[c] && cdb_rob[c] == issue_rs1_regfile_rob) begin
                w_i1_rdy = 1'b1;
                w_i1_v   = cdb_rd_v[c];
            end
            if (!w_i2_base && cdb_valid[c] && cdb_rob[c] == issue_rs2_regfile_rob) begin
                w_i2_rdy = 1'b1;
                w_i2_v   = cdb_rd_v[c];
            end
        end
`endif
    end

    always_comb begin
        w_free_idx = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--)
            if (!r_valid[i]) w_free_idx = IW'(i);
        w_sel_ok  = 1'b0;
        w_sel_idx = '0;
        w_best    = '1;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (r_valid[i] && !r_disp[i] && r_rdy1[i] && r_rdy2[i] &&
                (!w_sel_ok || r_rank[i] < w_best)) begin
                w_sel_ok  = 1'b1;
                w_sel_idx = IW'(i);
                w_best    = r_rank[i];
            end
        end
        w_lane_ok  = 1'b0;
        w_lane_idx = '0;
        w_hold_ok  = 1'b0;
        w_hold_idx = '0;
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
            if (r_ls[l] == L_IDLE) begin
                w_lane_ok  = 1'b1;
                w_lane_idx = LW'(l);
            end
            if (r_ls[l] == L_HOLD) begin
                w_hold_ok  = 1'b1;
                w_hold_idx = LW'(l);
            end
        end
        // A stalled result keeps ownership of the output until it transfers.
        w_out_lane  = r_lock_v ? r_lock_lane : w_hold_idx;
        w_issue     = rs_issue && !r_full;
        w_disp      = w_sel_ok && w_lane_ok;
        w_xfer      = w_hold_ok && out_ready;
        w_xfer_ent  = r_lent[w_out_lane];
        w_xfer_rank = r_rank[w_xfer_ent];
        w_cnt_nxt   = r_count + CW'(w_issue) - CW'(w_xfer);
        for (int l = 0; l < NUM_LANES; l++)
            w_mt[l] = (r_lf3[l] == 3'b011) ? 2'd2 :
                      (r_lf3[l] == 3'b010) ? 2'd1 : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_valid <= '0;
            r_disp  <= '0;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            for (int i = 0; i < RS_ENTRIES; i++) r_rank[i] <= '0;
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (r_valid[i]) begin
                    for (int c = 0; c < CDB_SIZE; c++) begin
                        if (cdb_valid[c] && !r_rdy1[i] && cdb_rob[c] == r_t1[i]) begin
                            r_rdy1[i] <= 1'b1;
                            r_v1[i]   <= cdb_rd_v[c];
                        end
                        if (cdb_valid[c] && !r_rdy2[i] && cdb_rob[c] == r_t2[i]) begin
                            r_rdy2[i] <= 1'b1;
                            r_v2[i]   <= cdb_rd_v[c];
                        end
                    end
                    if (w_xfer && r_rank[i] > w_xfer_rank)
                        r_rank[i] <= r_rank[i] - CW'(1);
                end
            end
            if (w_disp) r_disp[w_sel_idx] <= 1'b1;
            if (w_xfer) begin
                r_valid[w_xfer_ent] <= 1'b0;
                r_disp[w_xfer_ent]  <= 1'b0;
            end
            if (w_issue) begin
                r_valid[w_free_idx] <= 1'b1;
                r_disp[w_free_idx]  <= 1'b0;
                r_rdy1[w_free_idx]  <= w_i1_rdy;
                r_rdy2[w_free_idx]  <= w_i2_rdy;
                r_v1[w_free_idx]    <= w_i1_v;
                r_v2[w_free_idx]    <= w_i2_v;
                r_t1[w_free_idx]    <= issue_rs1_regfile_rob;
                r_t2[w_free_idx]    <= issue_rs2_regfile_rob;
                r_rob[w_free_idx]   <= issue_target_rob;
                r_f3[w_free_idx]    <= funct3;
                r_rank[w_free_idx]  <= w_xfer ? r_count - CW'(1) : r_count;
            end
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == CW'(RS_ENTRIES));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_lock_v    <= 1'b0;
            r_lock_lane <= '0;
            for (int l = 0; l < NUM_LANES; l++) r_ls[l] <= L_IDLE;
        end else begin
            r_lock_v    <= w_hold_ok && !out_ready;
            r_lock_lane <= w_out_lane;
            for (int l = 0; l < NUM_LANES; l++) begin
                unique case (r_ls[l])
                    L_IDLE: if (w_disp && w_lane_idx == LW'(l)) begin
                        r_la[l]   <= r_v1[w_sel_idx];
                        r_lb[l]   <= r_v2[w_sel_idx];
                        r_lf3[l]  <= r_f3[w_sel_idx];
                        r_lent[l] <= w_sel_idx;
                        r_lrob[l] <= r_rob[w_sel_idx];
                        r_ls[l]   <= L_START;
                    end
                    L_START: r_ls[l] <= L_BUSY;
                    L_BUSY: if (w_done[l]) begin
                        r_lp[l] <= (r_lf3[l] == 3'b000) ? w_prod[l][31:0] : w_prod[l][63:32];
                        r_ls[l] <= L_HOLD;
                    end
                    L_HOLD: if (w_xfer && w_out_lane == LW'(l)) r_ls[l] <= L_IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        shift_add_multiplier u_mul (
            .clk        (clk),
            .rst        (rst),
            .i_clear    (flush),
            .i_start    (r_ls[g] == L_START),
            .i_a        (r_la[g]),
            .i_b        (r_lb[g]),
            .i_mul_type (w_mt[g]),
            .o_done     (w_done[g]),
            .o_p        (w_prod[g])
        );
    end

    always_comb begin
        rs_full   = r_full;
        rs_count  = r_count;
        out_valid = w_hold_ok;
        out_p     = w_hold_ok ? r_lp[w_out_lane] : '0;
        out_rob   = w_hold_ok ? r_lrob[w_out_lane] : '0;
    end
endmodule

// File: tb/tb_mul_rs_multi.sv
// Directed bench for mul_rs_multi with a tag-indexed result scoreboard.
// Follows MUL_RS_ISSUE_BYPASS_EN to pick the expected issue-bypass behaviour.

module tb_mul_rs_multi;
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             rs_full;
    logic [3:0]       rs_count;
    logic             rs_issue = 1'b0;
    logic [2:0]       funct3 = '0;
    logic             r1_rf_rdy = 1'b0, r2_rf_rdy = 1'b0;
    logic [31:0]      r1_rf_v = '0, r2_rf_v = '0;
    logic [2:0]       r1_tag = '0, r2_tag = '0;
    logic             r1_rob_rdy = 1'b0, r2_rob_rdy = 1'b0;
    logic [31:0]      r1_rob_v = '0, r2_rob_v = '0;
    logic [2:0]       tgt = '0;
    logic [1:0]       cdb_valid = '0;
    logic [1:0][2:0]  cdb_rob = '0;
    logic [1:0][31:0] cdb_rd_v = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_p;
    logic [2:0]       out_rob;

    int total = 0;
    int bad = 0;

    mul_rs_multi #(.RS_ENTRIES(8), .NUM_LANES(2), .ROB_DEPTH(3), .CDB_SIZE(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rs_full(rs_full), .rs_count(rs_count),
        .rs_issue(rs_issue), .funct3(funct3),
        .issue_rs1_regfile_ready(r1_rf_rdy), .issue_rs2_regfile_ready(r2_rf_rdy),
        .issue_rs1_regfile_v(r1_rf_v), .issue_rs2_regfile_v(r2_rf_v),
        .issue_rs1_regfile_rob(r1_tag), .issue_rs2_regfile_rob(r2_tag),
        .issue_rs1_rob_ready(r1_rob_rdy), .issue_rs2_rob_ready(r2_rob_rdy),
        .issue_rs1_rob_v(r1_rob_v), .issue_rs2_rob_v(r2_rob_v),
        .issue_target_rob(tgt),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_rd_v(cdb_rd_v),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_rob(out_rob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference product from plain wide arithmetic.
    function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [65:0] sa, sb, pr;
        sa = (f == 3'd3) ? {34'd0, a} : {{34{a[31]}}, a};
        sb = (f == 3'd2 || f == 3'd3) ? {34'd0, b} : {{34{b[31]}}, b};
        pr = sa * sb;
        return (f == 3'd0) ? pr[31:0] : pr[63:32];
    endfunction

    logic        chk_en = 1'b0;
    logic [31:0] exp_a = '0, exp_b = '0;
    bit          pend [8];
    logic [31:0] pexp [8];
    int          m_count = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_p = '0;
    logic [2:0]  prev_rob = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rs_count", 32'(rs_count), 32'(m_count));
            chk("rs_full", 32'(rs_full), 32'(m_count == 8));
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_p", out_p, prev_p);
                chk("hold_rob", 32'(out_rob), 32'(prev_rob));
            end
            if (out_valid) begin
                chk("out_pending", 32'(pend[out_rob]), 32'd1);
                if (pend[out_rob]) chk("out_p", out_p, pexp[out_rob]);
            end
            prev_stall = out_valid && !out_ready && !flush;
            prev_p     = out_p;
            prev_rob   = out_rob;
            if (flush) begin
                for (int i = 0; i < 8; i++) pend[i] = 1'b0;
                m_count = 0;
            end else begin
                if (out_valid && out_ready) begin
                    pend[out_rob] = 1'b0;
                    m_count--;
                end
                if (rs_issue && (m_count + ((out_valid && out_ready) ? 1 : 0)) < 8) begin
                    pend[tgt] = 1'b1;
                    pexp[tgt] = ref_mul(funct3, exp_a, exp_b);
                    m_count++;
                end
            end
        end
    end

    // src: 0 regfile (ROB also offers junk), 1 ROB, 2 wait on tag
    task automatic do_issue(input logic [2:0] f, input int s1, input logic [31:0] v1,
                            input logic [2:0] t1, input int s2, input logic [31:0] v2,
                            input logic [2:0] t2, input logic [2:0] tg);
        funct3 = f; tgt = tg; rs_issue = 1'b1;
        exp_a = v1; exp_b = v2;
        r1_tag = t1; r2_tag = t2;
        r1_rf_rdy  = (s1 == 0); r1_rf_v  = (s1 == 0) ? v1 : 32'hDEAD0001;
        r1_rob_rdy = (s1 <= 1); r1_rob_v = (s1 == 1) ? v1 : 32'hBEEF0001;
        r2_rf_rdy  = (s2 == 0); r2_rf_v  = (s2 == 0) ? v2 : 32'hDEAD0002;
        r2_rob_rdy = (s2 <= 1); r2_rob_v = (s2 == 1) ? v2 : 32'hBEEF0002;
        @(posedge clk); #1;
        rs_issue = 1'b0;
        r1_rf_rdy = 1'b0; r1_rob_rdy = 1'b0; r2_rf_rdy = 1'b0; r2_rob_rdy = 1'b0;
    endtask

    task automatic bcast(input logic [1:0] v, input logic [2:0] t0, input logic [31:0] d0,
                         input logic [2:0] t1, input logic [31:0] d1);
        cdb_valid = v; cdb_rob[0] = t0; cdb_rd_v[0] = d0; cdb_rob[1] = t1; cdb_rd_v[1] = d1;
        @(posedge clk); #1;
        cdb_valid = '0;
    endtask

    task automatic wait_out(input int lim);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("wait_out_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        @(negedge clk);
        while ((m_count != 0 || out_valid) && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (m_count != 0 || out_valid) chk("wait_idle_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) pend[i] = 1'b0;
        chk("ref_mul", ref_mul(3'd0, 32'd7, 32'd6), 32'd42);
        chk("ref_mulh", ref_mul(3'd1, 32'h80000000, 32'd2), 32'hFFFFFFFF);
        chk("ref_mulhu", ref_mul(3'd3, 32'h80000000, 32'd2), 32'd1);
        chk("ref_mulhsu", ref_mul(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_full", 32'(rs_full), 32'd0);
        chk("rst_count", 32'(rs_count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_p", out_p, 32'd0);
        chk("rst_rob", 32'(out_rob), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        chk_en = 1'b1;

        // basic MUL
        out_ready = 1'b1;
        do_issue(3'd0, 0, 32'd7, 3'd0, 0, 32'd6, 3'd0, 3'd5);
        wait_out(100);
        chk("mul_p", out_p, 32'd42);
        chk("mul_rob", 32'(out_rob), 32'd5);
        wait_idle(100);

        // high-word variants, ROB-sourced operands on one
        do_issue(3'd1, 0, 32'h80000000, 3'd0, 0, 32'd2, 3'd0, 3'd1);
        do_issue(3'd3, 1, 32'h80000000, 3'd0, 0, 32'd2, 3'd0, 3'd2);
        do_issue(3'd2, 0, 32'hFFFFFFFF, 3'd0, 1, 32'hFFFFFFFF, 3'd0, 3'd3);
        wait_idle(200);

        // A waits on tag 3, B ready: B first; two ports match, port 1 wins
        do_issue(3'd0, 2, 32'd5, 3'd3, 0, 32'd11, 3'd0, 3'd4);
        do_issue(3'd0, 0, 32'd3, 3'd0, 0, 32'd4, 3'd0, 3'd6);
        wait_out(100);
        chk("order_rob", 32'(out_rob), 32'd6);
        chk("order_p", out_p, 32'd12);
        @(posedge clk); #1;
        bcast(2'b11, 3'd3, 32'd99, 3'd3, 32'd5);
        wait_out(100);
        chk("cdb_rob", 32'(out_rob), 32'd4);
        chk("cdb_p", out_p, 32'd55);
        wait_idle(100);

        // both lanes finish, output stalled, then drain with same-cycle issue
        out_ready = 1'b0;
        do_issue(3'd0, 0, 32'd100, 3'd0, 0, 32'd3, 3'd0, 3'd0);
        do_issue(3'd3, 0, 32'hFFFFFFFF, 3'd0, 0, 32'hFFFFFFFF, 3'd0, 3'd1);
        wait_out(100);
        repeat (4) @(negedge clk);
        chk("stall_rob", 32'(out_rob), 32'd0);
        chk("stall_p", out_p, 32'd300);
        @(posedge clk); #1;
        out_ready = 1'b1;
        do_issue(3'd0, 0, 32'd2, 3'd0, 0, 32'd2, 3'd0, 3'd2);
        @(negedge clk);
        chk("drain_rob", 32'(out_rob), 32'd1);
        chk("drain_p", out_p, 32'hFFFFFFFE);
        wait_idle(200);

        // fill, ignored ninth issue, flush mid-multiply
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            do_issue(3'd0, 0, 32'(i + 1), 3'd0, 0, 32'd3, 3'd0, 3'(i));
        do_issue(3'd0, 0, 32'd9, 3'd0, 0, 32'd9, 3'd0, 3'd0);
        @(negedge clk);
        chk("fill_full", 32'(rs_full), 32'd1);
        chk("fill_count", 32'(rs_count), 32'd8);
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_count", 32'(rs_count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (80) @(posedge clk);
        #1;

        // issue-time CDB capture
        cdb_valid = 2'b01; cdb_rob[0] = 3'd2; cdb_rd_v[0] = 32'd9;
        do_issue(3'd0, 2, 32'd9, 3'd2, 0, 32'd3, 3'd0, 3'd7);
        cdb_valid = '0;
`ifdef MUL_RS_ISSUE_BYPASS_EN
        wait_out(100);
        chk("byp_rob", 32'(out_rob), 32'd7);
        chk("byp_p", out_p, 32'd27);
`else
        repeat (60) @(negedge clk);
        chk("nobyp_valid", 32'(out_valid), 32'd0);
        chk("nobyp_count", 32'(rs_count), 32'd1);
        @(posedge clk); #1;
        bcast(2'b01, 3'd2, 32'd9, 3'd0, 32'd0);
        wait_out(100);
        chk("nobyp_rob", 32'(out_rob), 32'd7);
        chk("nobyp_p", out_p, 32'd27);
`endif
        wait_idle(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
